serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle 16-bit subtract unit that computes Z = A − B one digit per clock and reports the same five status flags as the team's combinational adder: carry, zero, sign, parity, overflow. It is the inverse-direction companion of that adder. It sits beside the adder in the datapath wherever area matters more than latency. A start/busy/done handshake connects it to the controlling sequencer.

## Interface
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per clock. WIDTH must be an integer multiple of DIGIT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when the block is not busy.
- A  input  WIDTH  minuend, captured on the accepting edge.
- B  input  WIDTH  subtrahend, captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: Z and the flags have just been updated.
- Z  output  WIDTH  registered result A − B, modulo 2^WIDTH.
- carry  output  1  borrow flag: 1 when A < B as unsigned values.
- zero  output  1  1 when Z == 0.
- sign  output  1  Z[WIDTH-1].
- parity  output  1  even parity, equal to ~^Z: 1 when Z has an even number of ones.
- overflow  output  1  signed overflow: (A[msb] & ~B[msb] & ~Z[msb]) | (~A[msb] & B[msb] & Z[msb]).

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch A and B into internal operand registers.
  - Set the internal carry-in to 1, so the unit computes A + ~B + 1.
  - Clear the digit counter.
  - Go to RUN.
- IDLE or DONE with start=0: go to, or stay in, IDLE.
- RUN, each cycle:
  - Compute digit k as A_k + ~B_k + c. A_k and B_k are bits [k·DIGIT +: DIGIT].
  - Write the digit sum into an internal accumulator and register the carry-out as c.
  - Increment the counter.
- RUN, on the edge that processes the last digit (k = WIDTH/DIGIT − 1):
  - Load Z from the accumulator.
  - Set carry = ~c_final.
  - Update zero, sign and parity from the new Z.
  - Update overflow from the latched operand MSBs and the new Z MSB.
  - Go to DONE.
- DONE lasts exactly one cycle: done=1, busy=0.
- start while in RUN is ignored. The operand registers are not disturbed.
- Z and all flags hold their last values between operations. They do not change during RUN.
- Arithmetic is unsigned modulo 2^WIDTH. The flags carry the signed interpretation.
- Reset, including reset asserted mid-RUN:
  - The state returns to IDLE.
  - Z, carry, zero, sign, parity, overflow, busy and done all go to 0.
  - The internal counter and accumulator are cleared.
  - Any partial result is discarded.
  - Flags are registered only at completion, so zero=0 after reset even though Z=0.
  - rst has priority over start on the same edge.

## Timing
- Accepting edge E0: the edge where start is sampled in IDLE or DONE. busy=1 from the cycle after E0.
- Digits are processed on edges E1 … E(N), where N = WIDTH/DIGIT (4 at the defaults).
- Z, the flags and done become visible in the cycle after E(N). With defaults, done is high in the 4th cycle after the E0 cycle, and busy falls in that same cycle.
- Throughput: start may be held or re-asserted during the DONE cycle. That gives back-to-back operations every N+1 cycles.
- done never overlaps busy. done is never high for two consecutive cycles.

## Test plan
- 0x0005 − 0x0003 -> Z=0x0002, carry=0, zero=0, sign=0, parity=0, overflow=0. done arrives exactly 4 cycles after the accepting edge.
- 0x0003 − 0x0005 -> Z=0xFFFE, carry=1, zero=0, sign=1, parity=0, overflow=0.
- 0x8000 − 0x0001 -> Z=0x7FFF, carry=0, sign=0, parity=0, overflow=1. Also 0x7FFF − 0xFFFF -> Z=0x8000, carry=1, sign=1, parity=0, overflow=1.
- 0xAAAA − 0xAAAA -> Z=0x0000, zero=1, parity=1, carry=0, overflow=0.
- Start 0x1234 − 0x0034, then pulse start with 0xFFFF/0xFFFF during RUN -> the second request is ignored and the result is Z=0x1200. Then hold start through the DONE cycle with 0x0001 − 0x0002 -> the next op is accepted with no IDLE gap and gives Z=0xFFFF, carry=1.
- Assert rst for one cycle mid-RUN -> all outputs read 0 on the next cycle and the state is IDLE. A following 0x0010 − 0x0001 completes correctly with Z=0x000F, parity=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor: operands in, result and flags out.
// The controlling sequencer holds the master side; the subtract unit holds the slave side.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             parity;
    logic             overflow;

    modport master (
        output start, A, B,
        input  busy, done, Z, carry, zero, sign, parity, overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Z, carry, zero, sign, parity, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial Z = A - B (A + ~B + 1), DIGIT bits per clock; done pulses WIDTH/DIGIT cycles after accept.
// start is only honoured in IDLE/DONE, so back-to-back ops run every WIDTH/DIGIT+1 cycles.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_zero;
    logic             r_sign;
    logic             r_parity;
    logic             r_overflow;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_result;

    assign w_a_dig = r_a[r_cnt*DIGIT +: DIGIT];
    assign w_b_dig = r_b[r_cnt*DIGIT +: DIGIT];
    assign w_sum   = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + (DIGIT+1)'(r_c);

    // Accumulator shifts right: after the last digit it holds the full result, newest digit on top.
    assign w_result = WIDTH'({w_sum[DIGIT-1:0], r_acc} >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_z        <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_c     <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_result;
                    r_c   <= w_sum[DIGIT];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_z        <= w_result;
                        r_carry    <= ~w_sum[DIGIT];
                        r_zero     <= (w_result == '0);
                        r_sign     <= w_result[WIDTH-1];
                        r_parity   <= ~^w_result;
                        r_overflow <= (r_a[WIDTH-1] & ~r_b[WIDTH-1] & ~w_result[WIDTH-1]) |
                                      (~r_a[WIDTH-1] & r_b[WIDTH-1] & w_result[WIDTH-1]);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.Z        = r_z;
    assign bus.carry    = r_carry;
    assign bus.zero     = r_zero;
    assign bus.sign     = r_sign;
    assign bus.parity   = r_parity;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [15:0] z;
        logic        c;
        logic        zr;
        logic        s;
        logic        p;
        logic        v;
    } exp_t;

    exp_t        cur_exp;
    logic [15:0] held_z;

    serial_subtractor_if #(.WIDTH(16)) bus ();

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sd;
        e.z  = 16'(int'(a) - int'(b));
        e.c  = (a < b);
        e.zr = (e.z == 16'h0);
        e.s  = e.z[15];
        e.p  = (($countones(e.z) % 2) == 0);
        sd   = int'($signed(a)) - int'($signed(b));
        e.v  = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one edge, then leave junk on the operand bus.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        cur_exp   = model(a, b);
        check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        check("done_low_after_accept", {31'b0, bus.done}, 32'd0);
    endtask

    // Wait for done; optionally fire a stray start mid-run. Ends in the DONE cycle.
    task automatic finish_op(input string tag, input bit stray);
        int n = 0;
        while (!bus.done && n < 20) begin
            check("z_hold_while_busy", {16'b0, bus.Z}, {16'b0, held_z});
            if (stray && n == 1) begin
                bus.start = 1'b1;
                bus.A     = 16'hFFFF;
                bus.B     = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, n, 4);
        check({tag, "_z"}, {16'b0, bus.Z}, {16'b0, cur_exp.z});
        check({tag, "_carry"}, {31'b0, bus.carry}, {31'b0, cur_exp.c});
        check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, cur_exp.zr});
        check({tag, "_sign"}, {31'b0, bus.sign}, {31'b0, cur_exp.s});
        check({tag, "_parity"}, {31'b0, bus.parity}, {31'b0, cur_exp.p});
        check({tag, "_overflow"}, {31'b0, bus.overflow}, {31'b0, cur_exp.v});
        check({tag, "_busy_in_done"}, {31'b0, bus.busy}, 32'd0);
        held_z = cur_exp.z;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_z"}, {16'b0, bus.Z}, 32'd0);
        check({tag, "_flags"}, {27'b0, bus.carry, bus.zero, bus.sign, bus.parity, bus.overflow}, 32'd0);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    endtask

    logic [15:0] dir_a [6] = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'hAAAA, 16'h0000};
    logic [15:0] dir_b [6] = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'hAAAA, 16'h0001};
    logic [15:0] dir_z [6] = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        held_z    = '0;
        cur_exp   = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");
        tick();

        // Directed cases with hand-computed results.
        for (int i = 0; i < 6; i++) begin
            launch(dir_a[i], dir_b[i]);
            finish_op("directed", 1'b0);
            check("directed_z_const", {16'b0, bus.Z}, {16'b0, dir_z[i]});
            tick();
            check("done_single_cycle", {31'b0, bus.done}, 32'd0);
        end

        // Stray start mid-run is ignored, then start held through DONE.
        launch(16'h1234, 16'h0034);
        finish_op("stray", 1'b1);
        check("stray_z_const", {16'b0, bus.Z}, 32'h1200);
        launch(16'h0001, 16'h0002);
        finish_op("b2b", 1'b0);
        check("b2b_z_const", {16'b0, bus.Z}, 32'hFFFF);
        tick();

        // Reset in the middle of a run.
        launch(16'h4321, 16'h1111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held_z = '0;
        check_all_zero("midrun_reset");
        for (int i = 0; i < 6; i++) begin
            check("no_done_after_reset", {31'b0, bus.done}, 32'd0);
            tick();
        end
        launch(16'h0010, 16'h0001);
        finish_op("post_reset", 1'b0);
        check("post_reset_z_const", {16'b0, bus.Z}, 32'h000F);
        check("post_reset_parity_const", {31'b0, bus.parity}, 32'd1);

        // Randomized operations, biased toward corner operands, random gaps.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            int gap;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 16'h8000;
                2: b = 16'h8000;
                3: a = 16'h7FFF;
                4: b = 16'hFFFF;
                default: ;
            endcase
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle_done_low", {31'b0, bus.done}, 32'd0);
            end
            launch(a, b);
            finish_op("rand", 1'b0);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
